moore_edge_counter: RTL and testbench

Moore-style edge detector and rising-edge counter that consumes a single-bit level signal, typically the `out` of the toggle flip-flop FSM, and sits directly downstream of it. It emits one-cycle rise and fall pulses that depend only on state, and counts rising edges up to a programmable terminal value. It asserts a sticky `done` flag when the terminal value is reached.

---
 rtl/edge_cnt_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 33 +++
 rtl/moore_edge_counter.sv | 110 +++++++++++
 tb/tb_moore_edge_counter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/edge_cnt_pkg.sv
// ============================================================================
// Package     : edge_cnt_pkg
// Description : Shared state encoding for the Moore edge detector/counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package edge_cnt_pkg;

  // Width of the encoded FSM state
  localparam int STATE_W = 3;

  // Moore FSM state encoding; values 5..7 are illegal and recover to S_INIT
  typedef enum logic [STATE_W-1:0] {
    S_INIT = 3'd0,
    S_LOW  = 3'd1,
    S_RISE = 3'd2,
    S_HIGH = 3'd3,
    S_FALL = 3'd4
  } state_e;

endpackage : edge_cnt_pkg

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module      : sync_2ff
// Description : 1-bit two-flop synchronizer, async active-low reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give metastability a full cycle to resolve
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff

`default_nettype wire

// File: rtl/moore_edge_counter.sv
// ============================================================================
// Module      : moore_edge_counter
// Description : Moore edge detector emitting one-cycle rise/fall pulses and
//               a saturating rising-edge counter with sticky done flag.
//               Optional input synchronizer: define MOORE_EDGE_CNT_SYNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module moore_edge_counter
  import edge_cnt_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int TERMINAL = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             clear,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  localparam logic [CNT_W-1:0] TERM_C = CNT_W'(TERMINAL);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  logic             samp;
  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_inc;
  logic             done_q;
  logic             done_d;

`ifdef MOORE_EDGE_CNT_SYNC_EN
  // Asynchronous source: resynchronize before the FSM sees it
  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d_i   (in),
    .q_o   (samp)
  );
`else
  // Source already lives in the clk domain
  assign samp = in;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; S_INIT never pulses so a level present at reset release is ignored
  always_comb begin
    state_d = S_INIT;
    case (state_q)
      S_INIT:  state_d = samp ? S_HIGH : S_LOW;
      S_LOW:   state_d = samp ? S_RISE : S_LOW;
      S_RISE:  state_d = samp ? S_HIGH : S_FALL;
      S_HIGH:  state_d = samp ? S_HIGH : S_FALL;
      S_FALL:  state_d = samp ? S_RISE : S_LOW;
      default: state_d = S_INIT;
    endcase
  end

  // Pulses decode purely from state
  assign rise_pulse = (state_q == S_RISE);
  assign fall_pulse = (state_q == S_FALL);

  assign count_inc = count_q + ONE_C;

  // Counter/done next values; clear takes priority over a coincident rise
  always_comb begin
    count_d = count_q;
    done_d  = done_q;
    if (clear) begin
      count_d = '0;
      done_d  = 1'b0;
    end else if ((state_q == S_RISE) && (count_q < TERM_C)) begin
      count_d = count_inc;
      if (count_inc == TERM_C) begin
        done_d = 1'b1;
      end
    end
  end

  // Counter and sticky done registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign done  = done_q;

endmodule : moore_edge_counter

`default_nettype wire

// File: tb/tb_moore_edge_counter.sv
// ============================================================================
// Module      : tb_moore_edge_counter
// Description : Directed self-checking bench for moore_edge_counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_moore_edge_counter;

  localparam int CNT_W    = 8;
  localparam int TERMINAL = 10;
`ifdef MOORE_EDGE_CNT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  // With the synchronizer, its flops reset to 0, so a high level at release
  // looks like a fresh rising edge once it reaches the FSM.
  localparam int INIT_HIGH_CNT = (LAT > 0) ? 1 : 0;

  logic             clk;
  logic             reset;
  logic             in;
  logic             clear;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] count;
  logic             done;

  int n_assert;
  int n_fail;
  int rise_cnt;
  int fall_cnt;
  int r0;
  int f0;

  moore_edge_counter #(
    .CNT_W    (CNT_W),
    .TERMINAL (TERMINAL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .clear      (clear),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .count      (count),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tallies, sampled mid-cycle
  always @(negedge clk) begin
    if (rise_pulse === 1'b1) rise_cnt = rise_cnt + 1;
    if (fall_pulse === 1'b1) fall_cnt = fall_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert = n_assert + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_in();
    in = 1'b1;
    repeat (2) tick();
    in = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rise_cnt = 0;
    fall_cnt = 0;

    // ---- Reset held with in=1
    reset = 1'b0;
    in    = 1'b1;
    clear = 1'b0;
    #3;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_rise",  32'(rise_pulse), 32'd0);
    chk("rst_fall",  32'(fall_pulse), 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    r0 = rise_cnt;
    repeat (LAT + 6) tick();
    chk("init_high_count", 32'(count), 32'(INIT_HIGH_CNT));
    chk("init_high_rises", 32'(rise_cnt - r0), 32'(INIT_HIGH_CNT));
    chk("init_high_fall",  32'(fall_pulse), 32'd0);

    // High level then drop: must have been in S_HIGH, so one fall pulse
    f0 = fall_cnt;
    in = 1'b0;
    repeat (LAT + 1) tick();
    chk("drop_fall_on", 32'(fall_pulse), 32'd1);
    tick();
    chk("drop_fall_off", 32'(fall_pulse), 32'd0);
    chk("drop_fall_num", 32'(fall_cnt - f0), 32'd1);

    // Normalize counter
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr0_count", 32'(count), 32'd0);
    chk("clr0_done",  32'(done), 32'd0);

    // ---- Single rise held for 5 cycles
    repeat (2) tick();
    r0 = rise_cnt;
    in = 1'b1;
    repeat (LAT) tick();
    tick();
    chk("rise1_pulse", 32'(rise_pulse), 32'd1);
    chk("rise1_cnt_pre", 32'(count), 32'd0);
    tick();
    chk("rise1_pulse_off", 32'(rise_pulse), 32'd0);
    chk("rise1_cnt_post", 32'(count), 32'd1);
    repeat (3) tick();
    chk("rise1_count", 32'(count), 32'd1);
    chk("rise1_num", 32'(rise_cnt - r0), 32'd1);

    // ---- Toggle every cycle to saturation
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr1_count", 32'(count), 32'd0);
    in = 1'b0;
    repeat (LAT) begin
      tick();
      in = ~in;
    end
    for (int j = 0; j < 28; j++) begin
      tick();
      chk($sformatf("tog_rise_%0d", j), 32'(rise_pulse), 32'(j % 2));
      chk($sformatf("tog_fall_%0d", j), 32'(fall_pulse), 32'((j + 1) % 2));
      chk($sformatf("tog_count_%0d", j), 32'(count), 32'(((j / 2) > TERMINAL) ? TERMINAL : (j / 2)));
      chk($sformatf("tog_done_%0d", j), 32'(done), 32'(((j / 2) >= TERMINAL) ? 1 : 0));
      in = ~in;
    end

    // ---- Clear coincident with S_RISE at count 4
    in = 1'b0;
    repeat (LAT + 3) tick();
    chk("sat_count_hold", 32'(count), 32'(TERMINAL));
    chk("sat_done_hold",  32'(done), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr2_done", 32'(done), 32'd0);
    repeat (4) pulse_in();
    repeat (LAT + 3) tick();
    chk("pre_clr_count", 32'(count), 32'd4);
    in = 1'b1;
    repeat (LAT) tick();
    tick();
    chk("clr_rise_pulse", 32'(rise_pulse), 32'd1);
    chk("clr_rise_cnt", 32'(count), 32'd4);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_win_count", 32'(count), 32'd0);
    chk("clr_win_done",  32'(done), 32'd0);
    repeat (3) tick();
    chk("clr_win_hold", 32'(count), 32'd0);

    // ---- Asynchronous reset mid-count at 7
    in = 1'b0;
    repeat (LAT + 3) tick();
    repeat (7) pulse_in();
    repeat (LAT + 3) tick();
    chk("pre_rst_count", 32'(count), 32'd7);
    in = 1'b1;
    repeat (LAT) tick();
    tick();
    chk("pre_rst_rise", 32'(rise_pulse), 32'd1);
    #2;
    reset = 1'b0;
    in    = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_done",  32'(done), 32'd0);
    chk("arst_rise",  32'(rise_pulse), 32'd0);
    chk("arst_fall",  32'(fall_pulse), 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (LAT + 3) tick();
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_fall",  32'(fall_pulse), 32'd0);

    // ---- One-cycle low glitch during a high level
    in = 1'b1;
    repeat (LAT + 4) tick();
    chk("glitch_pre_count", 32'(count), 32'd1);
    r0 = rise_cnt;
    f0 = fall_cnt;
    in = 1'b0;
    tick();
    in = 1'b1;
    repeat (LAT + 4) tick();
    chk("glitch_falls", 32'(fall_cnt - f0), 32'd1);
    chk("glitch_rises", 32'(rise_cnt - r0), 32'd1);
    chk("glitch_count", 32'(count), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_moore_edge_counter

`default_nettype wire
